// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
// The optional completion counter is enabled with DIV_PERF_CNT_EN.
package div_pkg;

  localparam int DIV_N = 20;
  localparam int DIV_CNT_W = $clog2(DIV_N);
  localparam logic [DIV_N-1:0] DIV_Q_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  function automatic int div_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step.
// Kept apart so the carry structure can change without touching the FSM.
module div_trial_sub #(
  parameter int W = 21
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define DIV_PERF_CNT_EN to add the perf_count completion counter.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
`ifdef DIV_PERF_CNT_EN
  ,
  output logic [31:0]    perf_count
`endif
);

  localparam int CW = div_cnt_w(N);
  localparam logic [N-1:0] Q_ONES = '1;

  div_state_t state, nxt;

  logic [N:0]    r_q;
  logic [N-1:0]  low_q;
  logic [N-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;

  logic          accept;
  logic          zero_c;
  logic          ovf_c;
  logic          last;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          borrow;
  logic [N:0]    r_nxt;
  logic [N-1:0]  low_nxt;

  assign accept  = in_valid & in_ready;
  assign zero_c  = (divisor == '0);
  assign ovf_c   = (dividend[2*N-1:N] >= divisor);
  assign last    = (cnt_q == CW'(N - 1));
  // R < divisor on entry, so the top bit of R is always zero here
  assign shifted = (N+1)'({r_q, low_q[N-1]});
  assign r_nxt   = borrow ? shifted : trial;
  assign low_nxt = {low_q[N-2:0], ~borrow};

  div_trial_sub #(
    .W (N + 1)
  ) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          nxt = (zero_c | ovf_c) ? DONE : CALC;
      end
      CALC: begin
        if (last) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= '0;
      low_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      div_by_zero <= zero_c;
      overflow    <= ~zero_c & ovf_c;
      dvs_q       <= divisor;
      cnt_q       <= '0;
      r_q         <= {1'b0, dividend[2*N-1:N]};
      low_q       <= dividend[N-1:0];
      if (zero_c | ovf_c) begin
        quotient  <= Q_ONES;
        remainder <= dividend[N-1:0];
      end
    end else if (state == CALC) begin
      r_q   <= r_nxt;
      low_q <= low_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        quotient  <= low_nxt;
        remainder <= r_nxt[N-1:0];
      end
    end
  end

`ifdef DIV_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    perf_count <= '0;
    else if (out_valid & out_ready) perf_count <= perf_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors, decoupled monitor.
// Build with DIV_PERF_CNT_EN to also check the completion counter.
module tb_seq_divider;

  localparam int N = 20;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    logic         ovf;
    int           acc;
    int           lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;
`ifdef DIV_PERF_CNT_EN
  logic [31:0]    perf_count;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic seen = 1'b0;
  exp_t exp_q[$];

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
`ifdef DIV_PERF_CNT_EN
    ,
    .perf_count  (perf_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle the DUT presents a result
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        chk("quotient", longint'(quotient), longint'(exp_q[0].q));
        chk("remainder", longint'(remainder), longint'(exp_q[0].r));
        chk("div_by_zero", longint'(div_by_zero), longint'(exp_q[0].dbz));
        chk("overflow", longint'(overflow), longint'(exp_q[0].ovf));
        if (!seen)
          chk("latency", longint'(cyc - exp_q[0].acc + 1), longint'(exp_q[0].lat));
        seen = 1'b1;
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                      input logic [N-1:0] q, input logic [N-1:0] r,
                      input logic dbz, input logic ovf, input int lat);
    exp_t e;
    int   n;
    n = 0;
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
      e.acc = cyc + 1;
      e.lat = lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", longint'(exp_q.size()), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
    chk({tag, "_quotient"}, longint'(quotient), 0);
    chk({tag, "_remainder"}, longint'(remainder), 0);
    chk({tag, "_dbz"}, longint'(div_by_zero), 0);
    chk({tag, "_ovf"}, longint'(overflow), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    send(40'd100, 20'd7, 20'd14, 20'd2, 1'b0, 1'b0, 21);
    in_valid = 1'b0;
    drain();
    send(40'h0000012345, 20'd0, 20'hFFFFF, 20'h12345, 1'b1, 1'b0, 1);
    in_valid = 1'b0;
    drain();
    send(40'h0000100000, 20'd1, 20'hFFFFF, 20'h00000, 1'b0, 1'b1, 1);
    in_valid = 1'b0;
    drain();
    send(40'hFFFFEFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFE, 1'b0, 1'b0, 21);
    in_valid = 1'b0;
    drain();
    send(40'd0, 20'd5, 20'd0, 20'd0, 1'b0, 1'b0, 21);
    in_valid = 1'b0;
    drain();

    // Backpressure with a second operand set waiting behind the stall
    do_reset();
    out_ready = 1'b0;
    send(40'd1000, 20'd3, 20'd333, 20'd1, 1'b0, 1'b0, 21);
    dividend = 40'd50;
    divisor  = 20'd5;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_wait", longint'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    send(40'd50, 20'd5, 20'd10, 20'd0, 1'b0, 1'b0, 21);
    in_valid = 1'b0;
    drain();
`ifdef DIV_PERF_CNT_EN
    chk("perf_b2b", longint'(perf_count), 2);
`endif

    // Reset in the middle of a calculation
    do_reset();
    in_valid = 1'b1;
    dividend = 40'd200;
    divisor  = 20'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(40'd9, 20'd4, 20'd2, 20'd1, 1'b0, 1'b0, 21);
    in_valid = 1'b0;
    drain();
`ifdef DIV_PERF_CNT_EN
    chk("perf_reset", longint'(perf_count), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
